// File: rtl/param_queue.sv
// Parametrised synchronous FIFO with ready/valid on both sides.
// Supports any depth (including non-power-of-2), optional empty-queue
// flow-through (FLOW), same-cycle replace when full (PIPE), an occupancy
// count and an almost-full flag.
module param_queue #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 2,
  parameter bit          FLOW     = 1'b0,
  parameter bit          PIPE     = 1'b0,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             io_enq_ready,
  input  logic             io_enq_valid,
  input  logic [WIDTH-1:0] io_enq_bits,
  input  logic             io_deq_ready,
  output logic             io_deq_valid,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [CW-1:0]    io_count,
  output logic             io_almost_full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
  logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
  logic             maybe_full_q, maybe_full_d;

  logic ptr_match, empty, full;
  logic do_flow, do_enq, do_deq;
  logic [CW:0] count_wide;
  logic unused_count_msb;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match & maybe_full_q;

  // Flow transfers bypass storage entirely when the queue is empty.
  assign do_flow = FLOW & empty & io_deq_ready & io_enq_valid;

  // PIPE lets a full queue accept when the head leaves in the same cycle.
  assign io_enq_ready = ~full | (PIPE & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW & io_enq_valid);
  assign io_deq_bits  = (FLOW && empty) ? io_enq_bits : mem_q[deq_ptr_q];

  assign do_enq = io_enq_ready & io_enq_valid & ~do_flow;
  assign do_deq = io_deq_ready & io_deq_valid & ~do_flow;

  // Storage write; not reset, and suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && do_enq) begin
      mem_q[enq_ptr_q] <= io_enq_bits;
    end
  end

  // Next-state for pointers and the full/empty disambiguation bit.
  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (do_enq) begin
      enq_ptr_d = ptr_inc(enq_ptr_q);
    end
    if (do_deq) begin
      deq_ptr_d = ptr_inc(deq_ptr_q);
    end
    if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  // Control state register with synchronous reset that overrides any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Occupancy from pointer distance, with one spare bit for the wrapped sum.
  always_comb begin
    if (full) begin
      count_wide = (CW + 1)'(DEPTH);
    end else if (enq_ptr_q >= deq_ptr_q) begin
      count_wide = (CW + 1)'(enq_ptr_q) - (CW + 1)'(deq_ptr_q);
    end else begin
      count_wide = (CW + 1)'(DEPTH) + (CW + 1)'(enq_ptr_q) - (CW + 1)'(deq_ptr_q);
    end
  end

  assign io_count         = count_wide[CW-1:0];
  assign unused_count_msb = count_wide[CW];
  assign io_almost_full   = (32'(io_count) >= AF_LEVEL);

endmodule

// File: tb/tb_param_queue.sv
// Scoreboard bench for param_queue: four configurations (base depth 2,
// base depth 3, flow-through, pipe). Stimulus pushes expected dequeue data
// into per-instance queues; monitors pop and compare on every deq handshake.
module tb_param_queue;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d2: base DEPTH=2
  logic       d2_er, d2_ev, d2_dr, d2_dv, d2_af;
  logic [7:0] d2_eb, d2_db;
  logic [1:0] d2_cnt;
  // d3: base DEPTH=3
  logic       d3_er, d3_ev, d3_dr, d3_dv, d3_af;
  logic [7:0] d3_eb, d3_db;
  logic [1:0] d3_cnt;
  // fl: FLOW=1 DEPTH=2
  logic       fl_er, fl_ev, fl_dr, fl_dv, fl_af;
  logic [7:0] fl_eb, fl_db;
  logic [1:0] fl_cnt;
  // pp: PIPE=1 DEPTH=2
  logic       pp_er, pp_ev, pp_dr, pp_dv, pp_af;
  logic [7:0] pp_eb, pp_db;
  logic [1:0] pp_cnt;

  logic [7:0] d2_q[$];
  logic [7:0] d3_q[$];
  logic [7:0] fl_q[$];
  logic [7:0] pp_q[$];

  param_queue #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .io_enq_ready(d2_er), .io_enq_valid(d2_ev), .io_enq_bits(d2_eb),
    .io_deq_ready(d2_dr), .io_deq_valid(d2_dv), .io_deq_bits(d2_db), .io_count(d2_cnt),
    .io_almost_full(d2_af)
  );
  param_queue #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .io_enq_ready(d3_er), .io_enq_valid(d3_ev), .io_enq_bits(d3_eb),
    .io_deq_ready(d3_dr), .io_deq_valid(d3_dv), .io_deq_bits(d3_db), .io_count(d3_cnt),
    .io_almost_full(d3_af)
  );
  param_queue #(.WIDTH(8), .DEPTH(2), .FLOW(1'b1)) u_fl (
    .clk(clk), .reset(reset), .io_enq_ready(fl_er), .io_enq_valid(fl_ev), .io_enq_bits(fl_eb),
    .io_deq_ready(fl_dr), .io_deq_valid(fl_dv), .io_deq_bits(fl_db), .io_count(fl_cnt),
    .io_almost_full(fl_af)
  );
  param_queue #(.WIDTH(8), .DEPTH(2), .PIPE(1'b1)) u_pp (
    .clk(clk), .reset(reset), .io_enq_ready(pp_er), .io_enq_valid(pp_ev), .io_enq_bits(pp_eb),
    .io_deq_ready(pp_dr), .io_deq_valid(pp_dv), .io_deq_bits(pp_db), .io_count(pp_cnt),
    .io_almost_full(pp_af)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitors: compare every completed dequeue against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && d2_dv && d2_dr) begin
      if (d2_q.size() == 0) chk("d2_unexpected_deq", {24'h0, d2_db}, 32'hFFFF_FFFF);
      else chk("d2_deq_bits", {24'h0, d2_db}, {24'h0, d2_q.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (!reset && d3_dv && d3_dr) begin
      if (d3_q.size() == 0) chk("d3_unexpected_deq", {24'h0, d3_db}, 32'hFFFF_FFFF);
      else chk("d3_deq_bits", {24'h0, d3_db}, {24'h0, d3_q.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (!reset && fl_dv && fl_dr) begin
      if (fl_q.size() == 0) chk("fl_unexpected_deq", {24'h0, fl_db}, 32'hFFFF_FFFF);
      else chk("fl_deq_bits", {24'h0, fl_db}, {24'h0, fl_q.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (!reset && pp_dv && pp_dr) begin
      if (pp_q.size() == 0) chk("pp_unexpected_deq", {24'h0, pp_db}, 32'hFFFF_FFFF);
      else chk("pp_deq_bits", {24'h0, pp_db}, {24'h0, pp_q.pop_front()});
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    {d2_ev, d2_dr, d3_ev, d3_dr, fl_ev, fl_dr, pp_ev, pp_dr} = '0;
    {d2_eb, d3_eb, fl_eb, pp_eb} = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    mid();
    chk("rst_enq_ready", 32'(d2_er), 32'd1);
    chk("rst_deq_valid", 32'(d2_dv), 32'd0);
    chk("rst_count", 32'(d2_cnt), 32'd0);
    chk("rst_almost_full", 32'(d2_af), 32'd0);
    chk("rst_flow_deq_valid", 32'(fl_dv), 32'd0);
    nxt();

    // DEPTH=3 fill then drain
    d3_ev = 1'b1; d3_eb = 8'h11; d3_q.push_back(8'h11);
    mid(); chk("d3_fill_cnt0", 32'(d3_cnt), 32'd0); chk("d3_fill_er0", 32'(d3_er), 32'd1);
    nxt();
    d3_eb = 8'h22; d3_q.push_back(8'h22);
    mid(); chk("d3_fill_cnt1", 32'(d3_cnt), 32'd1); chk("d3_fill_af1", 32'(d3_af), 32'd0);
    nxt();
    d3_eb = 8'h33; d3_q.push_back(8'h33);
    mid(); chk("d3_fill_cnt2", 32'(d3_cnt), 32'd2); chk("d3_fill_af2", 32'(d3_af), 32'd1);
    chk("d3_fill_er2", 32'(d3_er), 32'd1);
    nxt();
    d3_ev = 1'b0;
    mid(); chk("d3_full_cnt", 32'(d3_cnt), 32'd3); chk("d3_full_er", 32'(d3_er), 32'd0);
    chk("d3_full_af", 32'(d3_af), 32'd1); chk("d3_full_dv", 32'(d3_dv), 32'd1);
    nxt();
    d3_dr = 1'b1;
    repeat (3) begin
      mid();
      nxt();
    end
    mid(); chk("d3_drained_dv", 32'(d3_dv), 32'd0); chk("d3_drained_cnt", 32'(d3_cnt), 32'd0);
    nxt();

    // DEPTH=3 continuous streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      d3_ev = 1'b1; d3_eb = 8'(i); d3_q.push_back(8'(i));
      mid();
      if (i > 0) chk("d3_stream_cnt", 32'(d3_cnt), 32'd1);
      nxt();
    end
    d3_ev = 1'b0;
    mid(); chk("d3_stream_tail_cnt", 32'(d3_cnt), 32'd1);
    nxt();
    mid(); chk("d3_stream_end_cnt", 32'(d3_cnt), 32'd0); chk("d3_stream_end_dv", 32'(d3_dv), 32'd0);
    nxt();
    d3_dr = 1'b0;

    // FLOW: bypass when empty and consumer ready
    fl_ev = 1'b1; fl_eb = 8'hA5; fl_dr = 1'b1; fl_q.push_back(8'hA5);
    mid(); chk("fl_bypass_dv", 32'(fl_dv), 32'd1); chk("fl_bypass_db", 32'(fl_db), 32'hA5);
    chk("fl_bypass_cnt", 32'(fl_cnt), 32'd0);
    nxt();
    fl_ev = 1'b0;
    mid(); chk("fl_after_cnt", 32'(fl_cnt), 32'd0); chk("fl_after_dv", 32'(fl_dv), 32'd0);
    nxt();
    // FLOW: consumer stalled, entry is stored
    fl_ev = 1'b1; fl_eb = 8'h5A; fl_dr = 1'b0;
    mid(); chk("fl_stall_cnt", 32'(fl_cnt), 32'd0);
    nxt();
    fl_ev = 1'b0; fl_dr = 1'b1; fl_q.push_back(8'h5A);
    mid(); chk("fl_stored_cnt", 32'(fl_cnt), 32'd1);
    nxt();
    mid(); chk("fl_stored_drain_cnt", 32'(fl_cnt), 32'd0);
    nxt();
    fl_dr = 1'b0;

    // PIPE=1: replace while full
    pp_ev = 1'b1; pp_eb = 8'h01; pp_q.push_back(8'h01);
    nxt();
    pp_eb = 8'h02; pp_q.push_back(8'h02);
    mid(); chk("pp_fill_cnt", 32'(pp_cnt), 32'd1);
    nxt();
    mid(); chk("pp_full_er_stalled", 32'(pp_er), 32'd0);
    pp_eb = 8'h03; pp_dr = 1'b1; pp_q.push_back(8'h03);
    #1 chk("pp_replace_er", 32'(pp_er), 32'd1); chk("pp_replace_cnt", 32'(pp_cnt), 32'd2);
    chk("pp_replace_af", 32'(pp_af), 32'd1);
    nxt();
    pp_ev = 1'b0;
    mid(); chk("pp_after_cnt", 32'(pp_cnt), 32'd2);
    nxt();
    mid(); chk("pp_drain_cnt", 32'(pp_cnt), 32'd1);
    nxt();
    mid(); chk("pp_empty_cnt", 32'(pp_cnt), 32'd0); chk("pp_empty_dv", 32'(pp_dv), 32'd0);
    nxt();
    pp_dr = 1'b0;

    // PIPE=0: same stimulus, third entry refused
    d2_ev = 1'b1; d2_eb = 8'h01; d2_q.push_back(8'h01);
    nxt();
    d2_eb = 8'h02; d2_q.push_back(8'h02);
    nxt();
    d2_eb = 8'h03; d2_dr = 1'b1;
    mid(); chk("d2_full_er", 32'(d2_er), 32'd0); chk("d2_full_cnt", 32'(d2_cnt), 32'd2);
    nxt();
    d2_ev = 1'b0;
    mid(); chk("d2_drain_cnt", 32'(d2_cnt), 32'd1);
    nxt();
    mid(); chk("d2_empty_cnt", 32'(d2_cnt), 32'd0); chk("d2_empty_dv", 32'(d2_dv), 32'd0);
    nxt();
    d2_dr = 1'b0;

    // Reset while full with enq and deq presented
    d2_ev = 1'b1; d2_eb = 8'hC1;
    nxt();
    d2_eb = 8'hC2;
    nxt();
    d2_eb = 8'h77; d2_dr = 1'b1; reset = 1'b1;
    mid(); chk("rst_busy_cnt_before", 32'(d2_cnt), 32'd2);
    nxt();
    reset = 1'b0; d2_ev = 1'b0;
    mid(); chk("rst_busy_cnt", 32'(d2_cnt), 32'd0); chk("rst_busy_dv", 32'(d2_dv), 32'd0);
    chk("rst_busy_er", 32'(d2_er), 32'd1);
    nxt();
    mid(); chk("rst_busy_dv_later", 32'(d2_dv), 32'd0);
    nxt();
    d2_ev = 1'b1; d2_eb = 8'h44; d2_q.push_back(8'h44);
    mid(); chk("rst_fresh_cnt0", 32'(d2_cnt), 32'd0);
    nxt();
    d2_ev = 1'b0;
    mid(); chk("rst_fresh_cnt1", 32'(d2_cnt), 32'd1);
    nxt();
    mid(); chk("rst_fresh_empty", 32'(d2_dv), 32'd0);
    nxt();
    d2_dr = 1'b0;

    // Every expected entry must have been observed
    chk("d2_sb_empty", 32'(d2_q.size()), 32'd0);
    chk("d3_sb_empty", 32'(d3_q.size()), 32'd0);
    chk("fl_sb_empty", 32'(fl_q.size()), 32'd0);
    chk("pp_sb_empty", 32'(pp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
